apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB completer (slave) for the AHB-to-APB bridge. It answers transfers driven by the bridge's APB FSM controller on one bit of the bridge's 3-bit `Pselx` bus and backs them with a word-addressed register bank. It adds programmable wait states (`Pready`) and error reporting (`Pslverr`) for misaligned and out-of-range accesses.

## Interface
- `SLV_IDX`, default 0: which bit of `Pselx` selects this slave (0..2).
- `DEPTH`, default 16: number of 32-bit registers. Power of two, 2..256.
- `WAIT_CYCLES`, default 0: extra access-phase cycles before `Pready` rises (0..15).
- `Hclk` in 1: clock, all state on rising edge.
- `Hresetn` in 1: one clock; reset is asynchronous and active-low.
- `Pselx` in 3: select bus from the bridge; only bit `SLV_IDX` (`sel`) is used.
- `Penable` in 1: APB access-phase strobe.
- `Pwrite` in 1: 1 = write, 0 = read.
- `Paddr` in 32: byte address.
- `Pwdata` in 32: write data.
- `Prdata` out 32: read data, registered.
- `Pready` out 1: transfer completes in a cycle where `sel & Penable & Pready`. Registered.
- `Pslverr` out 1: error flag, valid only while `Pready`=1, else 0. Registered.

## Operation
- Reset (async, any time, including mid-transfer): state IDLE; `Prdata`=0, `Pready`=0, `Pslverr`=0; all registers 0; wait counter 0. The transfer in flight is dropped and no write is committed.
- Setup is detected in IDLE when `sel`=1 and `Penable`=0. The slave then captures `Pwrite` and `Paddr`.
- The decode error `err` is set when `Paddr[1:0]`≠0 or `Paddr[31:2]`≥`DEPTH`. The index is `Paddr[$clog2(DEPTH)+1:2]`.
- FSM states:
  - IDLE:
    - setup with `WAIT_CYCLES`=0 -> READY.
    - setup with `WAIT_CYCLES`>0 -> WAIT, counter loaded to `WAIT_CYCLES`.
    - otherwise stay in IDLE.
    - `Penable`=1 without a prior setup is ignored.
  - WAIT:
    - `sel`=0 -> IDLE (abort).
    - counter=1 -> READY.
    - otherwise decrement the counter.
  - READY (`Pready`=1):
    - `sel & Penable` -> complete the transfer and go to IDLE.
    - `sel`=0 -> abort to IDLE.
- Entering READY sets:
  - `Pready`<=1.
  - `Pslverr`<=`err`.
  - on a read, `Prdata`<=`err` ? 0 : `reg[idx]`.
- Write commit happens at the completion edge: `reg[idx]`<=`Pwdata` sampled at that edge. It is suppressed when `err`=1 or on abort.
- `Prdata` holds its value until the next read enters READY. Writes do not change `Prdata`.
- After completion or abort, `Pready` and `Pslverr` return to 0 on the following cycle.

## Timing
- Setup cycle T0, first access cycle T1.
  - `Pready`=1 during cycle T1+`WAIT_CYCLES`.
  - Access phase length is `WAIT_CYCLES`+1 cycles.
- Read data is taken from the bank at the edge entering READY.
  - A write that completes at the same edge is not visible to it.
  - No read-after-write bypass is needed: at most one transfer is active.
- Back-to-back: a new setup may arrive in the cycle immediately after completion. Since FSM is then in IDLE, it is accepted, so zero dead cycles.
- With `WAIT_CYCLES`=0 the slave is compatible with the bridge controller, which does not sample `Pready`.
- Address and control changing during the access phase are ignored, except `sel` (abort) and `Pwdata` (sampled at completion).

## Structure
- Package `apb_pkg` holds:
  - the state enum `apb_slv_state_t` {IDLE, WAIT, READY};
  - `APB_AW`=32 and `APB_DW`=32;
  - the `Pselx` width of 3.
- Sub-module `apb_slave_regbank`: `DEPTH`×32 array with async-reset flops. It has a write port (`we`, `widx`, `wdata`) and a combinational read port (`ridx`, `rdata`).
- Top level holds the FSM, wait counter, decode and output registers.

## Test plan
- Reset mid-transfer: drop `Hresetn` while in WAIT -> all outputs 0 immediately (asynchronously). The previously targeted register reads back 0.
- Write/read, `WAIT_CYCLES`=0: write 0xDEADBEEF to 0x08 -> `Pready`=1 in T1, `Pslverr`=0. Then read 0x08 -> `Prdata`=0xDEADBEEF in its T1.
- Wait states, `WAIT_CYCLES`=3: read 0x04 -> `Pready` low for T1..T3 and high in T4. Bank unchanged.
- Errors:
  - write to 0x41 (misaligned) -> `Pready`=1 with `Pslverr`=1; no register changes.
  - read 0x40 with `DEPTH`=16 -> `Pslverr`=1, `Prdata`=0.
- Abort: `sel` dropped in WAIT -> FSM returns to IDLE, `Pready` never rises, no write.
- Back-to-back and select decode:
  - write 0x0 then read 0x0 in the next cycle -> read returns the new data with no idle cycle.
  - transfers on other `Pselx` bits -> no response.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared bus widths and slave FSM state type for the APB completer.
package apb_pkg;
  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SELW = 3;
  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_slv_state_t;
endpackage

// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus between the bridge controller and its completers.
interface apb_slave_regfile_if;
  import apb_pkg::*;
  logic [APB_SELW-1:0] Pselx;
  logic Penable;
  logic Pwrite;
  logic [APB_AW-1:0] Paddr;
  logic [APB_DW-1:0] Pwdata;
  logic [APB_DW-1:0] Prdata;
  logic Pready;
  logic Pslverr;
  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata, Pready, Pslverr);
  modport slave (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata, Pready, Pslverr);
endinterface

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: DEPTH x 32 register array, one write port, combinational read port.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic Hclk,
  input  logic Hresetn,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [APB_DW-1:0] wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [APB_DW-1:0] rdata
);
  logic [APB_DW-1:0] mem [DEPTH];
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[widx] <= wdata;
  end
  assign rdata = mem[ridx];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with wait states, decode errors and a register bank.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int SLV_IDX = 0,
  parameter int DEPTH = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic Hclk,
  input logic Hresetn,
  apb_slave_regfile_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  apb_slv_state_t state;
  logic [3:0] cnt;
  logic wr_q, err_q;
  logic [IW-1:0] idx_q;
  logic [APB_DW-1:0] prdata, rdata;
  logic pready, pslverr;
  logic sel, setup, err_d, we, enter_ready, stay, cur_err, cur_wr;
  logic [IW-1:0] idx_d, ridx;
  assign sel = bus.Pselx[SLV_IDX];
  assign setup = state == IDLE && sel && !bus.Penable;
  assign idx_d = bus.Paddr[IW+1:2];
  assign err_d = bus.Paddr[1:0] != 2'b00 || bus.Paddr[APB_AW-1:2] >= (APB_AW-2)'(DEPTH);
  // From IDLE the transfer attributes come straight off the bus, later from the captured copy
  assign cur_err = state == IDLE ? err_d : err_q;
  assign cur_wr = state == IDLE ? bus.Pwrite : wr_q;
  assign ridx = state == IDLE ? idx_d : idx_q;
  assign enter_ready = (setup && WAIT_CYCLES == 0) || (state == WAIT && sel && cnt == 4'd1);
  assign stay = state == READY && sel && !bus.Penable;
  assign we = state == READY && sel && bus.Penable && wr_q && !err_q;
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      prdata <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (setup) begin
          wr_q <= bus.Pwrite;
          idx_q <= idx_d;
          err_q <= err_d;
          cnt <= 4'(WAIT_CYCLES);
          state <= WAIT_CYCLES == 0 ? READY : WAIT;
        end
        WAIT: if (!sel) state <= IDLE;
          else if (cnt == 4'd1) state <= READY;
          else cnt <= cnt - 4'd1;
        READY: if (!sel || bus.Penable) state <= IDLE;
        default: state <= IDLE;
      endcase
      pready <= enter_ready || (stay && pready);
      pslverr <= enter_ready ? cur_err : stay && pslverr;
      if (enter_ready && !cur_wr) prdata <= cur_err ? '0 : rdata;
    end
  end
  apb_slave_regbank #(.DEPTH(DEPTH)) u_bank (
    .Hclk(Hclk),
    .Hresetn(Hresetn),
    .we(we),
    .widx(idx_q),
    .wdata(bus.Pwdata),
    .ridx(ridx),
    .rdata(rdata)
  );
  assign bus.Prdata = prdata;
  assign bus.Pready = pready;
  assign bus.Pslverr = pslverr;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: table-driven and randomized checks of two slaves (no wait / 3 waits).
module tb_apb_slave_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] psel = '0;
  logic pen = 1'b0, pwr = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  int checks = 0, failures = 0;
  logic [31:0] m [2][16];
  logic [31:0] last [2];
  always #5 clk = ~clk;
  apb_slave_regfile_if b0 ();
  apb_slave_regfile_if b1 ();
  assign b0.Pselx = psel;
  assign b0.Penable = pen;
  assign b0.Pwrite = pwr;
  assign b0.Paddr = paddr;
  assign b0.Pwdata = pwdata;
  assign b1.Pselx = psel;
  assign b1.Penable = pen;
  assign b1.Pwrite = pwr;
  assign b1.Paddr = paddr;
  assign b1.Pwdata = pwdata;
  apb_slave_regfile #(.SLV_IDX(0), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (.Hclk(clk), .Hresetn(rst_n), .bus(b0.slave));
  apb_slave_regfile #(.SLV_IDX(1), .DEPTH(16), .WAIT_CYCLES(3)) dut1 (.Hclk(clk), .Hresetn(rst_n), .bus(b1.slave));
  typedef struct {
    int s;
    bit w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    bit er;
  } vec_t;
  vec_t tv[$];
  function automatic logic rdy(input int s);
    return s == 0 ? b0.Pready : b1.Pready;
  endfunction
  function automatic logic perr(input int s);
    return s == 0 ? b0.Pslverr : b1.Pslverr;
  endfunction
  function automatic logic [31:0] prd(input int s);
    return s == 0 ? b0.Prdata : b1.Prdata;
  endfunction
  function automatic bit merr(input logic [31:0] a);
    return a[1:0] != 2'b00 || a[31:2] >= 30'd16;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic model(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (w && !merr(a)) m[s][a[5:2]] = d;
    if (!w) last[s] = merr(a) ? 32'h0 : m[s][a[5:2]];
  endtask
  // Address/control are scrambled after setup and Pwdata only settles in the completing cycle
  task automatic xfer(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int wt, output logic oth);
    psel = 3'(1 << s);
    pen = 1'b0;
    pwr = w;
    paddr = a;
    pwdata = $urandom;
    @(posedge clk);
    #1 pen = 1'b1;
    paddr = $urandom;
    pwr = 1'($urandom);
    pwdata = $urandom;
    wt = 0;
    while (!rdy(s) && wt < 10) begin
      @(posedge clk);
      #1 pwdata = $urandom;
      wt++;
    end
    pwdata = d;
    rd = prd(s);
    er = perr(s);
    oth = rdy(1 - s);
    @(posedge clk);
    #1 psel = '0;
    pen = 1'b0;
  endtask
  task automatic run(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_er);
    logic [31:0] rd;
    logic er, oth;
    int wt;
    xfer(s, w, a, d, rd, er, wt, oth);
    chk($sformatf("wait s%0d a%h", s, a), 32'(wt), 32'(s == 0 ? 0 : 3));
    chk($sformatf("err s%0d a%h", s, a), 32'(er), 32'(exp_er));
    chk($sformatf("rdata s%0d a%h", s, a), rd, w ? last[s] : exp_rd);
    chk($sformatf("other s%0d a%h", s, a), 32'(oth), 32'h0);
    chk($sformatf("rdy_drop s%0d a%h", s, a), 32'({rdy(s), perr(s)}), 32'h0);
    model(s, w, a, d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
  initial begin
    logic [31:0] a, d;
    int k, s;
    bit w;
    for (int i = 0; i < 2; i++) begin
      last[i] = '0;
      for (int j = 0; j < 16; j++) m[i][j] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0", {b0.Prdata[31:2], b0.Prdata[1:0] | {b0.Pready, b0.Pslverr}}, 32'h0);
    chk("rst_out1", {b1.Prdata[31:2], b1.Prdata[1:0] | {b1.Pready, b1.Pslverr}}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tv.push_back('{0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0});
    tv.push_back('{0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0});
    tv.push_back('{1, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0});
    tv.push_back('{0, 1'b1, 32'h41, 32'h99999999, 32'h0, 1'b1});
    tv.push_back('{0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0});
    tv.push_back('{0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1});
    tv.push_back('{0, 1'b1, 32'h0A, 32'h55555555, 32'h0, 1'b1});
    tv.push_back('{0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0});
    tv.push_back('{0, 1'b1, 32'h00, 32'h12345678, 32'h0, 1'b0});
    tv.push_back('{0, 1'b0, 32'h00, 32'h0, 32'h12345678, 1'b0});
    tv.push_back('{1, 1'b1, 32'h3C, 32'hA5A5A5A5, 32'h0, 1'b0});
    tv.push_back('{1, 1'b0, 32'h3C, 32'h0, 32'hA5A5A5A5, 1'b0});
    tv.push_back('{0, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0});
    tv.push_back('{1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1});
    foreach (tv[i]) run(tv[i].s, tv[i].w, tv[i].a, tv[i].d, tv[i].rd, tv[i].er);
    // abort: dut1 loses its select one cycle into the wait phase
    psel = 3'b010;
    pen = 1'b0;
    pwr = 1'b1;
    paddr = 32'h10;
    pwdata = 32'h11112222;
    @(posedge clk);
    #1 pen = 1'b1;
    @(posedge clk);
    #1 psel = '0;
    pen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk($sformatf("abort_rdy%0d", i), 32'(b1.Pready), 32'h0);
    end
    run(1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    // a transfer on Pselx[2] belongs to neither slave
    psel = 3'b100;
    pen = 1'b0;
    pwr = 1'b1;
    paddr = 32'h08;
    pwdata = 32'h0BADF00D;
    @(posedge clk);
    #1 pen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk($sformatf("nosel_rdy%0d", i), 32'({b0.Pready, b1.Pready}), 32'h0);
    end
    psel = '0;
    pen = 1'b0;
    run(0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 80; i++) begin
      s = $urandom_range(0, 1);
      w = 1'($urandom);
      k = $urandom_range(0, 3);
      a = k == 0 ? 32'($urandom) :
          k == 1 ? 32'($urandom_range(0, 15)) << 2 :
          k == 2 ? (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3)) :
                   32'($urandom_range(16, 63)) << 2;
      d = $urandom;
      run(s, w, a, d, merr(a) ? 32'h0 : m[s][a[5:2]], merr(a));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    run(0, 1'b1, 32'h3C, 32'h77, 32'h0, 1'b0);
    run(0, 1'b0, 32'h3C, 32'h0, 32'h77, 1'b0);
    run(1, 1'b1, 32'h3C, 32'h88, 32'h0, 1'b0);
    run(1, 1'b0, 32'h3C, 32'h0, 32'h88, 1'b0);
    // async reset with dut0 in its ready cycle and dut1 in wait, both writing
    psel = 3'b011;
    pen = 1'b0;
    pwr = 1'b1;
    paddr = 32'h3C;
    pwdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 pen = 1'b1;
    chk("pre_rst_rdy0", 32'(b0.Pready), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 32'({b0.Pready, b0.Pslverr, b1.Pready, b1.Pslverr}), 32'h0);
    chk("arst_prd0", b0.Prdata, 32'h0);
    chk("arst_prd1", b1.Prdata, 32'h0);
    psel = '0;
    pen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last[i] = '0;
      for (int j = 0; j < 16; j++) m[i][j] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(0, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
    run(1, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
